// File: rtl/p3.sv
// RV32I-style decode stage: combinational decoder, 32x32 register file and write-back ALU.
// Optional build macro REGFILE_INIT_EN: reset loads x[i]=i instead of clearing the registers.
module p3 #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [XLEN-1:0] komut,
   output logic [6:0]      opcode,
   output logic [3:0]      aluop,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] imm,
   output logic            hata
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (op)
         4'b0000: r = a + b;
         4'b1000: r = a - b;
         4'b0001: r = a << b[4:0];
         4'b0010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0011: r = {{(XLEN-1){1'b0}}, (a < b)};
         4'b0100: r = a ^ b;
         4'b0101: r = a >> b[4:0];
         4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
         4'b0110: r = a | b;
         4'b0111: r = a & b;
         default: r = {XLEN{1'b0}};
      endcase
      return r;
   endfunction

   function automatic logic [XLEN-1:0] reg_init(input int idx);
`ifdef REGFILE_INIT_EN
      return XLEN'(idx);
`else
      return (idx < 0) ? XLEN'(idx) : {XLEN{1'b0}};
`endif
   endfunction

   logic [XLEN-1:0] regs_r [NREGS];
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   logic            r_ok_s, i_ok_s, br_ok_s;
   logic            alu_r_s, alu_i_s, addr_s, upper_s;
   logic [XLEN-1:0] alu_b_s, alu_res_s;
   logic            wr_en_s;

   assign opcode   = komut[6:0];
   assign rd       = komut[11:7];
   assign funct3_s = komut[14:12];
   assign rs1      = komut[19:15];
   assign rs2      = komut[24:20];
   assign funct7_s = komut[31:25];

   assign imm_i_s = {{20{komut[31]}}, komut[31:20]};
   assign imm_s_s = {{20{komut[31]}}, komut[31:25], komut[11:7]};
   assign imm_b_s = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
   assign imm_u_s = {komut[31:12], 12'd0};
   assign imm_j_s = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};

   // Only ADD and SRL have an alternate (funct7=0100000) form; shifts must carry a clean funct7.
   assign r_ok_s  = (funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
   assign i_ok_s  = (funct3_s == 3'b001) ? (funct7_s == 7'b0000000) :
                    (funct3_s == 3'b101) ? ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) :
                    1'b1;
   assign br_ok_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);

   // Instruction class, immediate, ALU op and legality decode.
   always_comb begin
      hata    = 1'b0;
      aluop   = 4'b0000;
      imm     = {XLEN{1'b0}};
      alu_r_s = 1'b0;
      alu_i_s = 1'b0;
      addr_s  = 1'b0;
      upper_s = 1'b0;
      case (opcode)
         OP_R: begin
            if (r_ok_s) begin
               aluop   = {funct7_s[5], funct3_s};
               alu_r_s = 1'b1;
            end else begin
               hata = 1'b1;
            end
         end
         OP_I: begin
            if (i_ok_s) begin
               aluop   = {((funct3_s == 3'b101) ? funct7_s[5] : 1'b0), funct3_s};
               imm     = imm_i_s;
               alu_i_s = 1'b1;
            end else begin
               hata = 1'b1;
            end
         end
         OP_LOAD: begin
            imm    = imm_i_s;
            addr_s = 1'b1;
         end
         OP_STORE: begin
            imm    = imm_s_s;
            addr_s = 1'b1;
         end
         OP_BRANCH: begin
            if (br_ok_s) begin
               aluop = {1'b0, funct3_s};
               imm   = imm_b_s;
            end else begin
               hata = 1'b1;
            end
         end
         OP_LUI, OP_AUIPC: begin
            imm     = imm_u_s;
            upper_s = 1'b1;
         end
         OP_JAL:  imm = imm_j_s;
         OP_JALR: imm = imm_i_s;
         default: hata = 1'b1;
      endcase
   end

   assign rs1_data = (rs1 == 5'd0) ? {XLEN{1'b0}} : regs_r[rs1];
   assign rs2_data = (rs2 == 5'd0) ? {XLEN{1'b0}} : regs_r[rs2];

   assign alu_b_s   = alu_r_s ? rs2_data : imm;
   assign alu_res_s = alu_calc(aluop, rs1_data, alu_b_s);

   // Write-back value selection; loads and stores only report the effective address.
   always_comb begin
      rd_data = {XLEN{1'b0}};
      if (alu_r_s || alu_i_s) begin
         rd_data = alu_res_s;
      end else if (upper_s) begin
         rd_data = imm;
      end else if (addr_s) begin
         rd_data = rs1_data + imm;
      end else begin
         rd_data = {XLEN{1'b0}};
      end
   end

   assign wr_en_s = we && !hata && (alu_r_s || alu_i_s || upper_s) && (rd != 5'd0);

   // Register file state; x0 is never written so it holds zero in every build.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= reg_init(i);
         end
      end else if (wr_en_s) begin
         regs_r[rd] <= rd_data;
      end
   end

endmodule

// File: tb/tb_p3.sv
// Scoreboard bench for p3: randomized instructions checked against a spec-level reference model.
module tb_p3;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] komut;
   logic [6:0]  opcode;
   logic [3:0]  aluop;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] rs1_data, rs2_data, rd_data, imm;
   logic        hata;

   p3 dut (
      .clk(clk), .reset(reset), .we(we), .komut(komut),
      .opcode(opcode), .aluop(aluop), .rs1(rs1), .rs2(rs2),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
      .rd_data(rd_data), .imm(imm), .hata(hata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] k;
      logic [6:0]  opcode;
      logic [3:0]  aluop;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rs1_data, rs2_data, rd_data, imm;
      logic        hata;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_x [32];
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                  K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_JALR = 9;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                      input logic [31:0] k);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s komut=%08h got=%08h expected=%08h", name, k, act, exp_v);
      end
   endtask

   function automatic logic [31:0] m_alu(input int code, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (code)
         0:  return a + b;
         8:  return a - b;
         1:  return a << sh;
         2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a ^ b;
         5:  return a >> sh;
         13: return $unsigned($signed(a) >>> sh);
         6:  return a | b;
         7:  return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
`ifdef REGFILE_INIT_EN
         model_x[i] = (i == 0) ? 32'd0 : 32'(i);
`else
         model_x[i] = 32'd0;
`endif
      end
   endtask

   // Reference: derive every output from the instruction's format rules, then retire into model_x.
   task automatic push_exp(input logic [31:0] k, input logic w);
      exp_t        e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          kind;
      int          code;
      logic [31:0] a, b;
      f3 = k[14:12];
      f7 = k[31:25];
      case (k[6:0])
         7'b0110011: kind = K_R;
         7'b0010011: kind = K_I;
         7'b0000011: kind = K_LD;
         7'b0100011: kind = K_ST;
         7'b1100011: kind = K_BR;
         7'b0110111: kind = K_LUI;
         7'b0010111: kind = K_AUIPC;
         7'b1101111: kind = K_JAL;
         7'b1100111: kind = K_JALR;
         default:    kind = K_ILL;
      endcase
      if (kind == K_R && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) kind = K_ILL;
      if (kind == K_I && f3 == 3'd1 && f7 != 7'h00) kind = K_ILL;
      if (kind == K_I && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) kind = K_ILL;
      if (kind == K_BR && (f3 == 3'd2 || f3 == 3'd3)) kind = K_ILL;

      e.k = k; e.opcode = k[6:0]; e.rd = k[11:7]; e.rs1 = k[19:15]; e.rs2 = k[24:20];
      e.hata = (kind == K_ILL);
      a = (e.rs1 == 5'd0) ? 32'd0 : model_x[e.rs1];
      b = (e.rs2 == 5'd0) ? 32'd0 : model_x[e.rs2];
      e.rs1_data = a; e.rs2_data = b;

      case (kind)
         K_I, K_LD, K_JALR: e.imm = 32'($signed(k[31:20]));
         K_ST:              e.imm = 32'($signed({k[31:25], k[11:7]}));
         K_BR:              e.imm = 32'($signed({k[31], k[7], k[30:25], k[11:8], 1'b0}));
         K_LUI, K_AUIPC:    e.imm = {k[31:12], 12'd0};
         K_JAL:             e.imm = 32'($signed({k[31], k[19:12], k[20], k[30:21], 1'b0}));
         default:           e.imm = 32'd0;
      endcase

      code = 0;
      if (kind == K_R) code = int'(f3) + (f7[5] ? 8 : 0);
      if (kind == K_I) code = int'(f3) + ((f3 == 3'd5 && f7[5]) ? 8 : 0);
      if (kind == K_BR) code = int'(f3);
      e.aluop = 4'(code);

      case (kind)
         K_R:            e.rd_data = m_alu(code, a, b);
         K_I:            e.rd_data = m_alu(code, a, e.imm);
         K_LUI, K_AUIPC: e.rd_data = e.imm;
         K_LD, K_ST:     e.rd_data = a + e.imm;
         default:        e.rd_data = 32'd0;
      endcase
      sb_q.push_back(e);

      if (reset && w && e.rd != 5'd0 &&
          (kind == K_R || kind == K_I || kind == K_LUI || kind == K_AUIPC))
         model_x[e.rd] = e.rd_data;
   endtask

   task automatic issue(input logic [31:0] k, input logic w);
      @(posedge clk);
      #1;
      komut = k;
      we    = w;
      push_exp(k, w);
   endtask

   task automatic issue_lit(input string name, input logic [31:0] k, input logic w,
                            input logic [31:0] exp_rd);
      issue(k, w);
      @(negedge clk);
      chk(name, rd_data, exp_rd, k);
   endtask

   // Reset asserted between edges while a write is pending; held one cycle, released off-edge.
   task automatic reset_pulse(input logic [31:0] k);
      @(posedge clk);
      #1;
      komut = k;
      we    = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      push_exp(k, 1'b1);
      issue(k, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      push_exp(komut, we);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [4:0]  rd_v, rs1_v, rs2_v;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] r;
      rd_v  = 5'($urandom_range(0, 31));
      rs1_v = 5'($urandom_range(0, 31));
      rs2_v = 5'($urandom_range(0, 31));
      f3    = 3'($urandom_range(0, 7));
      f7    = 7'($urandom());
      r     = $urandom();
      case ($urandom_range(0, 11))
         0, 1: begin
            case ($urandom_range(0, 3))
               0, 1: f7 = 7'h00;
               2: begin
                  f7 = 7'h20;
                  f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
               end
               default: f7 = 7'($urandom());
            endcase
            r = {f7, rs2_v, rs1_v, f3, rd_v, 7'b0110011};
         end
         2, 3: begin
            if (f3 == 3'd1 && $urandom_range(0, 3) != 0) f7 = 7'h00;
            if (f3 == 3'd5 && $urandom_range(0, 3) != 0) f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            r = {f7, rs2_v, rs1_v, f3, rd_v, 7'b0010011};
         end
         4:  r = {r[31:20], rs1_v, f3, rd_v, 7'b0000011};
         5:  r = {f7, rs2_v, rs1_v, f3, rd_v, 7'b0100011};
         6:  r = {f7, rs2_v, rs1_v, f3, rd_v, 7'b1100011};
         7:  r = {r[31:12], rd_v, 7'b0110111};
         8:  r = {r[31:12], rd_v, 7'b0010111};
         9:  r = {r[31:12], rd_v, 7'b1101111};
         10: r = {r[31:20], rs1_v, f3, rd_v, 7'b1100111};
         default: r = $urandom();
      endcase
      return r;
   endfunction

   // Monitor: compare the DUT against the oldest outstanding expectation each falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("opcode",   32'(opcode), 32'(e.opcode), e.k);
         chk("aluop",    32'(aluop),  32'(e.aluop),  e.k);
         chk("rs1",      32'(rs1),    32'(e.rs1),    e.k);
         chk("rs2",      32'(rs2),    32'(e.rs2),    e.k);
         chk("rd",       32'(rd),     32'(e.rd),     e.k);
         chk("rs1_data", rs1_data,    e.rs1_data,    e.k);
         chk("rs2_data", rs2_data,    e.rs2_data,    e.k);
         chk("rd_data",  rd_data,     e.rd_data,     e.k);
         chk("imm",      imm,         e.imm,         e.k);
         chk("hata",     32'(hata),   32'(e.hata),   e.k);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      we    = 1'b1;
      komut = 32'h0000FB01;
      model_reset();
      #2;
      push_exp(komut, we);
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;

      repeat (100) issue(32'h0000FB01, 1'b1);

      issue_lit("addi_x1",   32'h00500093, 1'b1, 32'd5);
      issue_lit("add_x3",    32'h001081B3, 1'b1, 32'd10);
      issue_lit("sub_x4",    32'h40100233, 1'b1, 32'hFFFFFFFB);
      issue_lit("srai_x5",   32'h40125293, 1'b1, 32'hFFFFFFFD);
      issue_lit("lui_x6",    32'hABCDE337, 1'b1, 32'hABCDE000);
      issue(32'h00700013, 1'b1);
      issue_lit("x0_x6_add", 32'h006004B3, 1'b1, 32'hABCDE000);
      issue_lit("we0_addi",  32'h00900093, 1'b0, 32'd9);
      issue_lit("x1_kept",   32'h00008533, 1'b1, 32'd5);
      issue_lit("addi_x2",   32'h06400113, 1'b1, 32'd100);
      issue_lit("sw_addr",   32'h00112423, 1'b1, 32'd108);
      issue(32'h000405B3, 1'b1);

      reset_pulse(32'h00308633);
      @(negedge clk);
`ifdef REGFILE_INIT_EN
      chk("post_reset_rs1", rs1_data, 32'd1, komut);
`else
      chk("post_reset_rs1", rs1_data, 32'd0, komut);
`endif
      issue(32'h000606B3, 1'b1);

      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 59) == 0) reset_pulse(gen_instr());
         else issue(gen_instr(), ($urandom_range(0, 7) != 0));
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(sb_q.size()), 32'd0, komut);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
